// File: rtl/shift_seq_unit.sv
// Iterative one-bit-per-clock shifter (LSL / LSR / ASR / pass) with valid/ready on both sides.
// Optional SHIFT_STICKY_EN adds out_sticky, the OR of all bits shifted out of the operand.
module shift_seq_unit #(
   parameter int WIDTH   = 4,
   parameter int SHAMT_W = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data
`ifdef SHIFT_STICKY_EN
   ,
   output logic               out_sticky
`endif
);

   // state | meaning
   // IDLE  | waiting for an operand, in_ready high
   // SHIFT | one bit shifted per edge, counter counts down to 1
   // DONE  | result presented, waiting for out_ready
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [1:0] OP_LSL  = 2'b00;
   localparam logic [1:0] OP_LSR  = 2'b01;
   localparam logic [1:0] OP_ASR  = 2'b10;
   localparam logic [1:0] OP_PASS = 2'b11;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   work, work_shift, result;
   logic [SHAMT_W-1:0] cnt;
   logic [1:0]         op;
   logic               accept;
   logic               skip_shift;
   logic               last_shift;

   assign accept     = in_valid && in_ready;
   assign skip_shift = (in_shamt == '0) || (in_op == OP_PASS);
   assign last_shift = (cnt == SHAMT_W'(1));

   always_comb begin
      work_shift = work;
      case (op)
         OP_LSL:  work_shift = {work[WIDTH-2:0], 1'b0};
         OP_LSR:  work_shift = {1'b0, work[WIDTH-1:1]};
         OP_ASR:  work_shift = {work[WIDTH-1], work[WIDTH-1:1]};
         default: work_shift = work;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = skip_shift ? DONE : SHIFT;
         SHIFT:   if (last_shift) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // in_ready is gated by rst_n so it reads low for the whole reset window
   always_comb begin
      in_ready  = rst_n && (state == IDLE);
      out_valid = (state == DONE);
   end

   // result is a separate register so out_data holds after the handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work   <= '0;
         cnt    <= '0;
         op     <= OP_LSL;
         result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  work <= in_data;
                  cnt  <= in_shamt;
                  op   <= in_op;
                  if (skip_shift) result <= in_data;
               end
            end
            SHIFT: begin
               work <= work_shift;
               cnt  <= cnt - SHAMT_W'(1);
               if (last_shift) result <= work_shift;
            end
            default: ;
         endcase
      end
   end

   assign out_data = result;

`ifdef SHIFT_STICKY_EN
   logic bit_out;
   logic sticky;

   always_comb begin
      bit_out = 1'b0;
      case (op)
         OP_LSL:         bit_out = work[WIDTH-1];
         OP_LSR, OP_ASR: bit_out = work[0];
         default:        bit_out = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky <= 1'b0;
      end else begin
         case (state)
            IDLE:    if (accept) sticky <= 1'b0;
            SHIFT:   sticky <= sticky | bit_out;
            default: ;
         endcase
      end
   end

   assign out_sticky = sticky;
`endif

endmodule

// File: tb/tb_shift_seq_unit.sv
// Scoreboard bench for shift_seq_unit: directed cases, backpressure, reset mid-shift, random sweep.
module tb_shift_seq_unit;
   localparam int WIDTH   = 4;
   localparam int SHAMT_W = 3;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [WIDTH-1:0]   in_data = '0;
   logic [SHAMT_W-1:0] in_shamt = '0;
   logic [1:0]         in_op = 2'b00;
   logic               out_valid;
   logic               out_ready = 1'b0;
   logic [WIDTH-1:0]   out_data;
`ifdef SHIFT_STICKY_EN
   logic               out_sticky;
`endif

   shift_seq_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_shamt  (in_shamt),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef SHIFT_STICKY_EN
      ,
      .out_sticky(out_sticky)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] data;
      logic             sticky;
      int               lat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] din,
                                            input logic [SHAMT_W-1:0] sh,
                                            input logic [1:0] op);
      int               n;
      logic [WIDTH-1:0] d;
      logic             s;
      n = int'(sh);
      s = 1'b0;
      if (op == 2'b11 || n == 0) return {1'b0, din};
      case (op)
         2'b00:   d = (n >= WIDTH) ? '0 : din << n;
         2'b01:   d = (n >= WIDTH) ? '0 : din >> n;
         default: d = (n >= WIDTH) ? {WIDTH{din[WIDTH-1]}} : WIDTH'($signed(din) >>> n);
      endcase
      for (int i = 0; i < WIDTH; i++) begin
         if (op == 2'b00) begin
            if (i >= WIDTH - n) s = s | din[i];
         end else begin
            if (i < n) s = s | din[i];
         end
      end
      return {s, d};
   endfunction

   task automatic run_op(input logic [WIDTH-1:0] din, input logic [SHAMT_W-1:0] sh,
                         input logic [1:0] op, input logic [WIDTH-1:0] exp_d,
                         input logic exp_s, input int hold, input string name);
      exp_t             e;
      int               waited;
      int               lat;
      logic [WIDTH-1:0] held;
      waited = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s accept_ready got %b want 1", name, in_ready);
      end
      in_valid = 1'b1;
      in_data  = din;
      in_shamt = sh;
      in_op    = op;
      e.data   = exp_d;
      e.sticky = exp_s;
      e.lat    = (op == 2'b11) ? 0 : int'(sh);
      @(posedge clk);
      sb.push_back(e);
      #1;
      in_valid = 1'b0;
      in_data  = ~din;
      in_shamt = SHAMT_W'($urandom);
      in_op    = 2'($urandom);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checks++;
      if (lat != e.lat) begin
         errors++;
         $display("FAIL %s latency got %0d want %0d", name, lat, e.lat);
      end
      held = out_data;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         checks++;
         if (out_data !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s backpressure data %h/%h in_ready %b valid %b want held, 0, 1",
                     name, out_data, held, in_ready, out_valid);
         end
      end
      @(negedge clk);
      out_ready = 1'b1;
      e = sb.pop_front();
      checks++;
      if (out_data !== e.data) begin
         errors++;
         $display("FAIL %s out_data got %b want %b", name, out_data, e.data);
      end
`ifdef SHIFT_STICKY_EN
      checks++;
      if (out_sticky !== e.sticky) begin
         errors++;
         $display("FAIL %s out_sticky got %b want %b", name, out_sticky, e.sticky);
      end
`endif
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== e.data) begin
         errors++;
         $display("FAIL %s post_handshake valid %b in_ready %b data %b want 0 1 %b",
                  name, out_valid, in_ready, out_data, e.data);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_state valid %b data %b in_ready %b want 0 0000 0",
                  out_valid, out_data, in_ready);
      end
`ifdef SHIFT_STICKY_EN
      checks++;
      if (out_sticky !== 1'b0) begin
         errors++;
         $display("FAIL reset_sticky got %b want 0", out_sticky);
      end
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release in_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_directed();
      run_op(4'b1001, 3'd2, 2'b10, 4'b1110, 1'b1, 0, "asr_2");
      run_op(4'b1001, 3'd2, 2'b01, 4'b0010, 1'b1, 0, "lsr_2");
      run_op(4'b0011, 3'd2, 2'b00, 4'b1100, 1'b0, 0, "lsl_2");
      run_op(4'b0101, 3'd1, 2'b10, 4'b0010, 1'b1, 0, "asr_1_pos");
   endtask

   task automatic test_overshift();
      run_op(4'b1000, 3'd7, 2'b10, 4'b1111, 1'b1, 0, "asr_7");
      run_op(4'b0011, 3'd5, 2'b00, 4'b0000, 1'b1, 0, "lsl_5");
      run_op(4'b1010, 3'd4, 2'b01, 4'b0000, 1'b1, 0, "lsr_4");
   endtask

   task automatic test_pass();
      run_op(4'b0110, 3'd0, 2'b00, 4'b0110, 1'b0, 0, "shamt0");
      run_op(4'b0110, 3'd5, 2'b11, 4'b0110, 1'b0, 0, "op_pass");
   endtask

   task automatic test_back_to_back();
      run_op(4'b1101, 3'd3, 2'b00, 4'b1000, 1'b1, 3, "bp_lsl_3");
      run_op(4'b0111, 3'd1, 2'b01, 4'b0011, 1'b1, 0, "b2b_lsr_1");
   endtask

   task automatic test_reset_mid_shift();
      int seen;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 4'b0001;
      in_shamt = 3'd6;
      in_op    = 2'b00;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset valid %b data %b in_ready %b want 0 0000 0",
                  out_valid, out_data, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_release in_ready got %b want 1", in_ready);
      end
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL mid_reset_stale valid_cycles got %0d want 0", seen);
      end
   endtask

   task automatic test_random();
      logic [WIDTH-1:0]   d;
      logic [SHAMT_W-1:0] sh;
      logic [1:0]         op;
      logic [WIDTH:0]     m;
      for (int i = 0; i < 40; i++) begin
         d  = WIDTH'($urandom);
         sh = SHAMT_W'($urandom);
         op = 2'($urandom);
         m  = model(d, sh, op);
         run_op(d, sh, op, m[WIDTH-1:0], m[WIDTH], int'($urandom_range(0, 2)), "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_overshift();
      test_pass();
      test_back_to_back();
      test_reset_mid_shift();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
